// File: rtl/ysyx_24080014_ifu.sv
// ysyx_24080014_ifu: instruction fetch unit, one outstanding AXI4-Lite read, flush-safe drain
module ysyx_24080014_ifu #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        flush,
  output logic [31:0] fetch_cnt
);
  typedef enum logic [2:0] {IDLE, AR, R, OUT, DRAIN} state_t;
  state_t state, state_n;
  logic drop, drop_n;
  logic [31:0] addr_q;
  logic accept, mis, capture, deliver;
  assign accept  = pc_valid && pc_ready;
  assign mis     = MISALIGN_CHECK && (pc[1:0] != 2'b00);
  assign capture = (state == R) && rvalid && !drop && !flush;
  assign deliver = inst_valid && inst_ready;
  assign araddr  = addr_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end
  // A flushed read still has to complete on the bus; drop remembers to discard it.
  always_comb begin
    state_n = state;
    drop_n  = drop;
    case (state)
      IDLE:  state_n = accept ? (mis ? OUT : AR) : IDLE;
      AR: begin
        drop_n  = drop || flush;
        state_n = arready ? ((drop || flush) ? DRAIN : R) : AR;
      end
      R: begin
        drop_n  = rvalid ? 1'b0 : (drop || flush);
        state_n = rvalid ? (capture ? OUT : IDLE) : R;
      end
      OUT:   state_n = (flush || inst_ready) ? IDLE : OUT;
      DRAIN: begin
        drop_n  = rvalid ? 1'b0 : drop;
        state_n = rvalid ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    pc_ready   = (state == IDLE) && !flush;
    arvalid    = rst && (state == AR);
    rready     = rst && ((state == R) || (state == DRAIN));
    inst_valid = rst && (state == OUT) && !flush;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= '0;
      inst      <= '0;
      inst_pc   <= '0;
      inst_err  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      if (accept) begin
        addr_q  <= pc;
        inst_pc <= pc;
        if (mis) begin
          inst     <= '0;
          inst_err <= 1'b1;
        end
      end
      if (capture) begin
        inst     <= rdata;
        inst_err <= |rresp;
      end
      if (deliver) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// tb_ysyx_24080014_ifu: per-cycle vector table plus reset and counter-wrap sequences
module tb_ysyx_24080014_ifu;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc = '0, araddr, rdata = '0, inst, inst_pc, fetch_cnt;
  logic pc_valid = 1'b0, pc_ready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0] rresp = '0;
  logic inst_err, inst_valid, inst_ready = 1'b0, flush = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ysyx_24080014_ifu dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .flush(flush), .fetch_cnt(fetch_cnt)
  );

  typedef struct {
    logic r; logic [31:0] p; logic pv, arr, rv; logic [31:0] rd; logic [1:0] rr; logic ir, fl;
    logic [3:0] ctl; logic [31:0] ad, in, ip; logic er; logic [31:0] cn;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(logic r, logic [31:0] p, logic pv, logic arr, logic rv, logic [31:0] rd,
                             logic [1:0] rr, logic ir, logic fl, logic [3:0] ctl, logic [31:0] ad,
                             logic [31:0] in, logic [31:0] ip, logic er, logic [31:0] cn);
    vec_t t;
    t = '{r, p, pv, arr, rv, rd, rr, ir, fl, ctl, ad, in, ip, er, cn};
    return t;
  endfunction

  task automatic drive(input logic r, input logic [31:0] p, input logic pv, arr, rv,
                       input logic [31:0] rd, input logic [1:0] rr, input logic ir, fl);
    rst = r; pc = p; pc_valid = pv; arready = arr; rvalid = rv;
    rdata = rd; rresp = rr; inst_ready = ir; flush = fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] ctl, input logic [31:0] ad, in, ip,
                         input logic er, input logic [31:0] cn);
    chk({nm, " ctl"}, {28'd0, pc_ready, arvalid, rready, inst_valid}, {28'd0, ctl});
    chk({nm, " araddr"}, araddr, ad);
    chk({nm, " inst"}, inst, in);
    chk({nm, " inst_pc"}, inst_pc, ip);
    chk({nm, " inst_err"}, {31'd0, inst_err}, {31'd0, er});
    chk({nm, " fetch_cnt"}, fetch_cnt, cn);
  endtask

  localparam logic [31:0] A = 32'h8000_0000, B2 = 32'h8000_0002, B4 = 32'h8000_0004,
    B8 = 32'h8000_0008, BC = 32'h8000_000c, B10 = 32'h8000_0010, B14 = 32'h8000_0014,
    B18 = 32'h8000_0018, B1C = 32'h8000_001c, I1 = 32'h0000_0413, I2 = 32'h0010_0093,
    DB = 32'hdead_beef, N13 = 32'h0000_0013, I3 = 32'h0050_0513;

  initial begin
    // reset state, then basic fetch at minimum latency
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0));
    tv.push_back(v(1, A, 1, 1, 0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0));
    tv.push_back(v(1, A, 1, 1, 0, 0, 0, 0, 0, 4'b0100, A, 0, A, 0, 0));
    tv.push_back(v(1, A, 1, 0, 1, I1, 0, 0, 0, 4'b0010, A, 0, A, 0, 0));
    tv.push_back(v(1, A, 1, 0, 0, 0, 0, 0, 0, 4'b0001, A, I1, A, 0, 0));
    tv.push_back(v(1, A, 1, 0, 0, 0, 0, 1, 0, 4'b0001, A, I1, A, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, A, I1, A, 0, 1));
    // arready stalls 5 cycles, inst_ready stalls 4 cycles
    tv.push_back(v(1, B4, 1, 0, 0, 0, 0, 0, 0, 4'b1000, A, I1, A, 0, 1));
    for (int i = 0; i < 5; i++) tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, B4, I1, B4, 0, 1));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, B4, I1, B4, 0, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, B4, I1, B4, 0, 1));
    tv.push_back(v(1, 0, 0, 0, 1, I2, 0, 0, 0, 4'b0010, B4, I1, B4, 0, 1));
    for (int i = 0; i < 4; i++) tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, B4, I2, B4, 0, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001, B4, I2, B4, 0, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, B4, I2, B4, 0, 2));
    // bus error response
    tv.push_back(v(1, B8, 1, 1, 0, 0, 0, 0, 0, 4'b1000, B4, I2, B4, 0, 2));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, B8, I2, B8, 0, 2));
    tv.push_back(v(1, 0, 0, 0, 1, DB, 2, 0, 0, 4'b0010, B8, I2, B8, 0, 2));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001, B8, DB, B8, 1, 2));
    // misaligned pc: no bus request, straight to OUT
    tv.push_back(v(1, B2, 1, 0, 0, 0, 0, 0, 0, 4'b1000, B8, DB, B8, 1, 3));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, B2, 0, B2, 1, 3));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001, B2, 0, B2, 1, 3));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, B2, 0, B2, 1, 4));
    // flush in AR with arready low, then drain
    tv.push_back(v(1, BC, 1, 0, 0, 0, 0, 0, 0, 4'b1000, B2, 0, B2, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0100, BC, 0, BC, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, BC, 0, BC, 1, 4));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, BC, 0, BC, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, BC, 0, BC, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 1, 32'h1234_5678, 0, 1, 0, 4'b0010, BC, 0, BC, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, BC, 0, BC, 1, 4));
    // flush in R together with rvalid, then flush blocks pc_ready in IDLE
    tv.push_back(v(1, B10, 1, 1, 0, 0, 0, 0, 0, 4'b1000, BC, 0, BC, 1, 4));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, B10, 0, B10, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 1, 32'haaaa_aaaa, 0, 0, 1, 4'b0010, B10, 0, B10, 1, 4));
    tv.push_back(v(1, 32'h8000_0020, 1, 0, 0, 0, 0, 0, 1, 4'b0000, B10, 0, B10, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, B10, 0, B10, 1, 4));
    // flush in OUT with inst_ready high: no handshake, no count
    tv.push_back(v(1, B14, 1, 1, 0, 0, 0, 0, 0, 4'b1000, B10, 0, B10, 1, 4));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, B14, 0, B14, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 1, N13, 0, 0, 0, 4'b0010, B14, 0, B14, 1, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000, B14, N13, B14, 0, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, B14, N13, B14, 0, 4));
    // flush in R before rvalid: response dropped when it arrives
    tv.push_back(v(1, B18, 1, 1, 0, 0, 0, 0, 0, 4'b1000, B14, N13, B14, 0, 4));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, B18, N13, B18, 0, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0010, B18, N13, B18, 0, 4));
    tv.push_back(v(1, 0, 0, 0, 1, 32'hbbbb_bbbb, 0, 0, 0, 4'b0010, B18, N13, B18, 0, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, B18, N13, B18, 0, 4));
    // normal fetch afterwards proves drop was cleared
    tv.push_back(v(1, B1C, 1, 1, 0, 0, 0, 0, 0, 4'b1000, B18, N13, B18, 0, 4));
    tv.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, B1C, N13, B1C, 0, 4));
    tv.push_back(v(1, 0, 0, 0, 1, I3, 0, 0, 0, 4'b0010, B1C, N13, B1C, 0, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001, B1C, I3, B1C, 0, 4));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, B1C, I3, B1C, 0, 5));

    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].r, tv[i].p, tv[i].pv, tv[i].arr, tv[i].rv, tv[i].rd, tv[i].rr, tv[i].ir, tv[i].fl);
      #1;
      chk_all($sformatf("row%0d", i), tv[i].ctl, tv[i].ad, tv[i].in, tv[i].ip, tv[i].er, tv[i].cn);
    end

    // reset asserted while in R abandons the read
    @(negedge clk); drive(1, 32'h8000_0020, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_in_R ctl", {28'd0, pc_ready, arvalid, rready, inst_valid}, 32'h0);
    @(negedge clk); #1 chk_all("rst_after", 4'b1000, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_release pc_ready", {31'd0, pc_ready}, 32'd1);

    // fetch counter wraps
    force dut.fetch_cnt = 32'hffff_ffff;
    #1 release dut.fetch_cnt;
    chk("wrap preset", fetch_cnt, 32'hffff_ffff);
    drive(1, A, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 1, N13, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("wrap inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("wrap inst", inst, N13);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("wrap fetch_cnt", fetch_cnt, 32'h0);
    chk("wrap pc_ready", {31'd0, pc_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
